spm_program_loader: RTL

Boot-time loader sitting directly upstream of the SPM memory unit. It accepts a byte stream over a valid/ready handshake and writes it into consecutive memory addresses from a programmable base. It then releases the memory port and the processor. While idle or done, it passes the processor's address/data/write straight through to memory, acting as the memory-port arbiter.

---
 rtl/spm_pkg.sv | 26 ++
 rtl/spm_mem_port_mux.sv | 30 +++
 rtl/spm_program_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared constants, loader state encoding and arithmetic helpers for the SPM program loader.
package spm_pkg;

   localparam int WORD_SIZE   = 8;
   localparam int MEMORY_SIZE = 256;

   localparam logic [WORD_SIZE-1:0] PTR_LAST = WORD_SIZE'(MEMORY_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } loader_state_e;

   function automatic logic [WORD_SIZE-1:0] csum_add(input logic [WORD_SIZE-1:0] acc,
                                                     input logic [WORD_SIZE-1:0] val);
      return acc + val;
   endfunction

   // Addresses wrap at MEMORY_SIZE, which need not be a power of two of WORD_SIZE.
   function automatic logic [WORD_SIZE-1:0] ptr_next(input logic [WORD_SIZE-1:0] ptr);
      return (ptr == PTR_LAST) ? {WORD_SIZE{1'b0}} : ptr + WORD_SIZE'(1);
   endfunction

endpackage

// File: rtl/spm_mem_port_mux.sv
// Memory-port arbiter: the loader owns the SPM port while busy, the processor otherwise.
module spm_mem_port_mux
   import spm_pkg::*;
(
   input  logic                 busy,
   input  logic [WORD_SIZE-1:0] loader_address,
   input  logic [WORD_SIZE-1:0] loader_data,
   input  logic                 loader_write,
   input  logic [WORD_SIZE-1:0] cpu_address,
   input  logic [WORD_SIZE-1:0] cpu_data,
   input  logic                 cpu_write,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_data_in,
   output logic                 mem_write
);

   // Select the port owner.
   always_comb begin
      if (busy) begin
         mem_address = loader_address;
         mem_data_in = loader_data;
         mem_write   = loader_write;
      end else begin
         mem_address = cpu_address;
         mem_data_in = cpu_data;
         mem_write   = cpu_write;
      end
   end

endmodule

// File: rtl/spm_program_loader.sv
// Boot-time SPM program loader: streams bytes into memory from a base address, then releases the CPU.
// Optional read-back checksum pass is enabled with `define SPM_LOADER_VERIFY_EN.
module spm_program_loader
   import spm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] base_addr,
   input  logic [WORD_SIZE-1:0] length,
   input  logic [WORD_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] cpu_address,
   input  logic [WORD_SIZE-1:0] cpu_data,
   input  logic                 cpu_write,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_data_in,
   output logic                 mem_write,
   input  logic [WORD_SIZE-1:0] mem_data_out,
   output logic                 busy,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error
);

   loader_state_e        state_q, state_d;
   logic [WORD_SIZE-1:0] ptr_q, ptr_d;
   logic [WORD_SIZE-1:0] rem_q, rem_d;
   logic                 busy_q, busy_d;
   logic                 in_ready_q, in_ready_d;
   logic                 done_q, done_d;
`ifdef SPM_LOADER_VERIFY_EN
   logic [WORD_SIZE-1:0] sum_q, sum_d;
   logic [WORD_SIZE-1:0] rsum_q, rsum_d;
   logic [WORD_SIZE-1:0] base_q, base_d;
   logic [WORD_SIZE-1:0] len_q, len_d;
   logic                 error_q, error_d;
`else
   logic                 unused_verify_s;
   assign unused_verify_s = ^mem_data_out;
`endif

   // Next-state and datapath decisions for the load/verify sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      in_ready_d = in_ready_q;
      done_d     = done_q;
`ifdef SPM_LOADER_VERIFY_EN
      sum_d      = sum_q;
      rsum_d     = rsum_q;
      base_d     = base_q;
      len_d      = len_q;
      error_d    = error_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ptr_d  = base_addr;
               rem_d  = length;
               done_d = 1'b0;
`ifdef SPM_LOADER_VERIFY_EN
               sum_d   = {WORD_SIZE{1'b0}};
               base_d  = base_addr;
               len_d   = length;
               error_d = 1'b0;
`endif
               if (length == {WORD_SIZE{1'b0}}) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  in_ready_d = 1'b0;
               end else begin
                  state_d    = ST_LOAD;
                  busy_d     = 1'b1;
                  in_ready_d = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (in_valid && in_ready_q) begin
               ptr_d = ptr_next(ptr_q);
               rem_d = rem_q - WORD_SIZE'(1);
`ifdef SPM_LOADER_VERIFY_EN
               sum_d = csum_add(sum_q, in_data);
`endif
               if (rem_q == WORD_SIZE'(1)) begin
                  in_ready_d = 1'b0;
`ifdef SPM_LOADER_VERIFY_EN
                  state_d = ST_VERIFY;
                  ptr_d   = base_q;
                  rem_d   = len_q;
                  rsum_d  = {WORD_SIZE{1'b0}};
`else
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_VERIFY: begin
`ifdef SPM_LOADER_VERIFY_EN
            rsum_d = csum_add(rsum_q, mem_data_out);
            ptr_d  = ptr_next(ptr_q);
            rem_d  = rem_q - WORD_SIZE'(1);
            if (rem_q == WORD_SIZE'(1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               error_d = (csum_add(rsum_q, mem_data_out) != sum_q);
            end else begin
               state_d = ST_VERIFY;
            end
`else
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
`endif
         end
         default: begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
            done_d     = 1'b0;
         end
      endcase
   end

   // Loader state and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= {WORD_SIZE{1'b0}};
         rem_q      <= {WORD_SIZE{1'b0}};
         busy_q     <= 1'b0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef SPM_LOADER_VERIFY_EN
         sum_q      <= {WORD_SIZE{1'b0}};
         rsum_q     <= {WORD_SIZE{1'b0}};
         base_q     <= {WORD_SIZE{1'b0}};
         len_q      <= {WORD_SIZE{1'b0}};
         error_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
`ifdef SPM_LOADER_VERIFY_EN
         sum_q      <= sum_d;
         rsum_q     <= rsum_d;
         base_q     <= base_d;
         len_q      <= len_d;
         error_q    <= error_d;
`endif
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;
`ifdef SPM_LOADER_VERIFY_EN
   assign error    = error_q;
`else
   assign error    = 1'b0;
`endif

   // The write strobe is gated by in_ready so VERIFY never writes.
   spm_mem_port_mux u_mem_port_mux (
      .busy           (busy_q),
      .loader_address (ptr_q),
      .loader_data    (in_data),
      .loader_write   (in_valid & in_ready_q),
      .cpu_address    (cpu_address),
      .cpu_data       (cpu_data),
      .cpu_write      (cpu_write),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_write      (mem_write)
   );

endmodule
